// File: rtl/mmio_bus.sv
// mmio_bus: data-side interconnect steering CPU accesses to data memory or the MMIO page
// (GPIO, cycle counter, periodic timer with sticky irq, sticky halt flag).
module mmio_bus #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_memwrite,
    input  logic [n-1:0] cpu_adr,
    input  logic [n-1:0] cpu_wdata,
    output logic [n-1:0] cpu_rdata,
    output logic         dmem_we,
    input  logic [n-1:0] dmem_rdata,
    input  logic [n-1:0] gpio_in,
    output logic [n-1:0] gpio_out,
    output logic         irq,
    output logic         halted
);
    logic         mmio_sel, wr, fire;
    logic [7:0]   off;
    logic [n-1:0] sync1, sync2, cycle, cmp, tcnt, reg_rdata;

    assign mmio_sel = &cpu_adr[n-1:8];
    assign off      = cpu_adr[7:0];
    assign wr       = cpu_memwrite & mmio_sel;
    assign dmem_we  = cpu_memwrite & ~mmio_sel;
    // Period is exactly cmp cycles: count 0..cmp-1, fire on the wrap.
    assign fire     = (cmp != '0) && (tcnt == cmp - n'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out <= '0;
            sync1    <= '0;
            sync2    <= '0;
            cycle    <= '0;
            cmp      <= '0;
            tcnt     <= '0;
            irq      <= 1'b0;
            halted   <= 1'b0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            cycle <= cycle + n'(1);
            if (wr && off == 8'h00) gpio_out <= cpu_wdata;
            if (wr && off == 8'h06) begin
                cmp  <= cpu_wdata;
                tcnt <= '0;
            end else begin
                tcnt <= (cmp == '0 || fire) ? '0 : tcnt + n'(1);
            end
            // A fire on the same edge as a W1C clear keeps the flag set.
            if (fire) irq <= 1'b1;
            else if (wr && off == 8'h08 && cpu_wdata[0]) irq <= 1'b0;
            if (wr && off == 8'h0A && cpu_wdata[0]) halted <= 1'b1;
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (off)
            8'h00: reg_rdata = gpio_out;
            8'h02: reg_rdata = sync2;
            8'h04: reg_rdata = cycle;
            8'h06: reg_rdata = cmp;
            8'h08: reg_rdata = {{(n-1){1'b0}}, irq};
            8'h0A: reg_rdata = {{(n-1){1'b0}}, halted};
            default: reg_rdata = '0;
        endcase
    end

    assign cpu_rdata = mmio_sel ? reg_rdata : dmem_rdata;
endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: directed vector table, timer/halt/reset sequences and randomized traffic
// checked against an event-count reference model of the MMIO page.
module tb_mmio_bus;
    localparam int N = 16;
    logic         clk = 1'b0, reset, cpu_memwrite, dmem_we, irq, halted;
    logic [N-1:0] cpu_adr, cpu_wdata, cpu_rdata, dmem_rdata, gpio_in, gpio_out;

    mmio_bus #(.n(N)) dut (
        .clk(clk), .reset(reset), .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .irq(irq), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model: time is measured in edges since reset; the timer fires
    // whenever a whole number of periods has elapsed since cmp was loaded.
    int          m_edge = 0, m_load = 0;
    logic [15:0] m_gout = 0, m_cmp = 0;
    logic        m_irq = 0, m_halt = 0;
    logic [15:0] hist[$];

    logic [15:0] cap_rd, cap_gout;
    logic        cap_we, cap_irq, cap_halt;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_gin();
        return hist.size() >= 2 ? hist[0] : 16'h0;
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a, input logic [15:0] dm);
        if (a[15:8] != 8'hFF) return dm;
        case (a[7:0])
            8'h00: return m_gout;
            8'h02: return m_gin();
            8'h04: return 16'(m_edge);
            8'h06: return m_cmp;
            8'h08: return {15'b0, m_irq};
            8'h0A: return {15'b0, m_halt};
            default: return 16'h0;
        endcase
    endfunction

    task automatic m_update(input logic we, input logic [15:0] a, wd, gi, input logic rs);
        int  e;
        logic fire, mw;
        if (rs) begin
            m_edge = 0; m_load = 0; m_gout = 0; m_cmp = 0; m_irq = 0; m_halt = 0;
            hist.delete();
        end else begin
            e    = m_edge + 1;
            fire = (m_cmp != 0) && ((e - m_load) % int'(m_cmp) == 0);
            mw   = we && (a[15:8] == 8'hFF);
            if (mw && a[7:0] == 8'h00) m_gout = wd;
            if (mw && a[7:0] == 8'h06) begin
                m_cmp  = wd;
                m_load = e;
            end
            if (fire) m_irq = 1;
            else if (mw && a[7:0] == 8'h08 && wd[0]) m_irq = 0;
            if (mw && a[7:0] == 8'h0A && wd[0]) m_halt = 1;
            hist.push_back(gi);
            if (hist.size() > 2) void'(hist.pop_front());
            m_edge = e;
        end
    endtask

    // One bus cycle: drive on the falling edge, check against the model, clock the model.
    task automatic step(input logic we, input logic [15:0] a, wd, dm, gi, input logic rs);
        @(negedge clk);
        cpu_memwrite = we; cpu_adr = a; cpu_wdata = wd; dmem_rdata = dm; gpio_in = gi; reset = rs;
        #1;
        cap_rd = cpu_rdata; cap_we = dmem_we; cap_irq = irq; cap_halt = halted; cap_gout = gpio_out;
        chk("rdata", cap_rd, m_read(a, dm));
        chk("dmem_we", {15'b0, cap_we}, {15'b0, we && a[15:8] != 8'hFF});
        chk("gpio_out", cap_gout, m_gout);
        chk("irq", {15'b0, cap_irq}, {15'b0, m_irq});
        chk("halted", {15'b0, cap_halt}, {15'b0, m_halt});
        @(posedge clk);
        m_update(we, a, wd, gi, rs);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] a, wd, dm, gi, exp_rd;
        logic        exp_we;
    } vec_t;
    vec_t tbl[13];

    initial begin
        int          first;
        logic [15:0] gi, a, wd;
        logic        we;
        tbl[0]  = '{1'b0, 16'hFF04, 16'h0000, 16'h1111, 16'h0000, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 16'hFF04, 16'h0000, 16'h1111, 16'h0000, 16'h0001, 1'b0};
        tbl[2]  = '{1'b0, 16'hFF04, 16'h0000, 16'h1111, 16'h0000, 16'h0002, 1'b0};
        tbl[3]  = '{1'b0, 16'hFF04, 16'h0000, 16'h1111, 16'h0000, 16'h0003, 1'b0};
        tbl[4]  = '{1'b0, 16'hFF00, 16'h0000, 16'h1111, 16'h0000, 16'h0000, 1'b0};
        tbl[5]  = '{1'b1, 16'h0010, 16'h1234, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b1};
        tbl[6]  = '{1'b1, 16'hFF00, 16'hA5A5, 16'h1111, 16'h0000, 16'h0000, 1'b0};
        tbl[7]  = '{1'b0, 16'hFF00, 16'h0000, 16'h1111, 16'h0000, 16'hA5A5, 1'b0};
        tbl[8]  = '{1'b0, 16'hFF02, 16'h0000, 16'h1111, 16'h00F0, 16'h0000, 1'b0};
        tbl[9]  = '{1'b0, 16'hFF02, 16'h0000, 16'h1111, 16'h00F0, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 16'hFF02, 16'h0000, 16'h1111, 16'h00F0, 16'h00F0, 1'b0};
        tbl[11] = '{1'b0, 16'hFF0C, 16'h0000, 16'h1111, 16'h00F0, 16'h0000, 1'b0};
        tbl[12] = '{1'b0, 16'hFF03, 16'h0000, 16'h1111, 16'h00F0, 16'h0000, 1'b0};

        reset = 1; cpu_memwrite = 0; cpu_adr = 0; cpu_wdata = 0; dmem_rdata = 0; gpio_in = 0;
        repeat (2) @(posedge clk);
        m_update(0, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            step(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].dm, tbl[i].gi, 0);
            chk($sformatf("tbl%0d_rd", i), cap_rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_we", i), {15'b0, cap_we}, {15'b0, tbl[i].exp_we});
        end

        gi = 16'h00F0;
        step(1, 16'hFF06, 16'd5, 0, gi, 0);
        first = -1;
        for (int k = 0; k < 10 && first < 0; k++) begin
            step(0, 16'hFF08, 0, 0, gi, 0);
            if (cap_irq) first = k;
        end
        chk("irq_rise", 16'(first), 16'd5);
        step(1, 16'hFF08, 16'h0001, 0, gi, 0);
        first = -1;
        for (int k = 0; k < 10 && first < 0; k++) begin
            step(0, 16'hFF08, 0, 0, gi, 0);
            if (k == 0) chk("irq_clr", {15'b0, cap_irq}, 16'h0);
            if (cap_irq) first = k;
        end
        chk("irq_refire", 16'(first), 16'd3);
        step(1, 16'hFF08, 16'h0001, 0, gi, 0);
        step(1, 16'hFF06, 16'h0000, 0, gi, 0);
        for (int k = 0; k < 12; k++) begin
            step(0, 16'hFF06, 0, 0, gi, 0);
            chk("timer_off", {15'b0, cap_irq}, 16'h0);
        end

        step(1, 16'hFF06, 16'd4, 0, gi, 0);
        repeat (3) step(0, 16'hFF04, 0, 0, gi, 0);
        step(1, 16'hFF08, 16'h0001, 0, gi, 0);
        step(0, 16'hFF08, 0, 0, gi, 0);
        chk("set_wins", {15'b0, cap_irq}, 16'h1);
        chk("stat_rd", cap_rd, 16'h1);
        step(1, 16'hFF06, 16'h0000, 0, gi, 0);
        step(1, 16'hFF08, 16'h0001, 0, gi, 0);

        step(1, 16'hFF0C, 16'hFFFF, 0, gi, 0);
        step(0, 16'hFF0C, 0, 0, gi, 0);
        chk("unmapped_rd", cap_rd, 16'h0);
        chk("unmapped_gout", cap_gout, 16'hA5A5);

        step(1, 16'hFF0A, 16'h0001, 0, gi, 0);
        step(1, 16'hFF0A, 16'h0000, 0, gi, 0);
        chk("halt_set", {15'b0, cap_halt}, 16'h1);
        step(0, 16'hFF0A, 0, 0, gi, 0);
        chk("halt_sticky", cap_rd, 16'h1);

        step(1, 16'hFF00, 16'h00FF, 0, gi, 1);
        step(0, 16'hFF04, 0, 0, gi, 0);
        chk("rst_gout", cap_gout, 16'h0);
        chk("rst_halt", {15'b0, cap_halt}, 16'h0);
        chk("rst_cycle", cap_rd, 16'h0);

        for (int i = 0; i < 3000; i++) begin
            we = 1'($urandom);
            if ($urandom_range(0, 3) == 0) a = {8'($urandom_range(0, 254)), 8'($urandom)};
            else a = {8'hFF, 8'($urandom_range(0, 15))};
            wd = (a[7:0] == 8'h06) ? 16'($urandom_range(0, 12)) : 16'($urandom);
            if ($urandom_range(0, 7) == 0) gi = 16'($urandom);
            step(we, a, wd, 16'($urandom), gi, $urandom_range(0, 63) == 0);
        end

        step(0, 16'hFF04, 0, 0, gi, 1);
        for (int i = 0; i < 65535; i++) step(0, 16'hFF04, 0, 0, gi, 0);
        step(0, 16'hFF04, 0, 0, gi, 0);
        chk("cycle_max", cap_rd, 16'hFFFF);
        step(0, 16'hFF04, 0, 0, gi, 0);
        chk("cycle_wrap", cap_rd, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
